// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu (shared by alu_arbiter)
//  Description : 4-bit combinational ALU. op 00 add, 01 sub, 10 and, 11 or.
//                carry is bit 4 of the 5-bit sum/difference (borrow for sub),
//                0 for the logic ops; zero flags y == 0.
//  Ports       : i_a, i_b (operands), i_op (opcode) -> o_y, o_carry, o_zero
//  Revision    : 1.0 - initial release
// ============================================================================
module alu (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [1:0] i_op,
    output logic [3:0] o_y,
    output logic       o_carry,
    output logic       o_zero
);
    logic [4:0] w_res;

    always_comb begin
        w_res = '0;
        case (i_op)
            2'b00:   w_res = {1'b0, i_a} + {1'b0, i_b};
            2'b01:   w_res = {1'b0, i_a} - {1'b0, i_b};
            2'b10:   w_res = {1'b0, i_a & i_b};
            default: w_res = {1'b0, i_a | i_b};
        endcase
    end

    assign o_y     = w_res[3:0];
    assign o_carry = w_res[4];
    assign o_zero  = (w_res[3:0] == 4'd0);
endmodule

// ============================================================================
//  Module      : alu_arbiter
//  Description : Two requesters share one ALU. IDLE grants one requester
//                (round-robin on contention), EXEC computes for one cycle,
//                RESP holds the result until rsp_ready. done_cnt counts
//                completed response handshakes and saturates.
//  Ports       : clk, rst (async, active high)
//                reqN_valid/ready, reqN_a, reqN_b, reqN_op  (N = 0, 1)
//                rsp_valid/ready, rsp_id, rsp_y, rsp_carry, rsp_zero
//                done_cnt [CNT_W-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_y,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] done_cnt
);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prio;      // 0: requester 0 wins a tie, 1: requester 1
    logic [3:0]       r_a;
    logic [3:0]       r_b;
    logic [1:0]       r_op;
    logic             r_id;
    logic [3:0]       r_y;
    logic             r_carry;
    logic             r_zero;
    logic             r_rsp_id;
    logic [CNT_W-1:0] r_cnt;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_done;
    logic [3:0]       w_alu_y;
    logic             w_alu_carry;
    logic             w_alu_zero;

    alu u_alu (
        .i_a     (r_a),
        .i_b     (r_b),
        .i_op    (r_op),
        .o_y     (w_alu_y),
        .o_carry (w_alu_carry),
        .o_zero  (w_alu_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A lone requester always wins; on a tie the pointer decides.
                if (req0_valid && (!req1_valid || !r_prio)) begin
                    w_grant0 = 1'b1;
                end else if (req1_valid) begin
                    w_grant1 = 1'b1;
                end
                if (req0_valid || req1_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_id     <= 1'b0;
            r_y      <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_rsp_id <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_grant0) begin
                r_a    <= req0_a;
                r_b    <= req0_b;
                r_op   <= req0_op;
                r_id   <= 1'b0;
                r_prio <= 1'b1;
            end else if (w_grant1) begin
                r_a    <= req1_a;
                r_b    <= req1_b;
                r_op   <= req1_op;
                r_id   <= 1'b1;
                r_prio <= 1'b0;
            end
            // Result registers double as the response outputs, so they only
            // change in EXEC and hold across and after the handshake.
            if (r_state == S_EXEC) begin
                r_y      <= w_alu_y;
                r_carry  <= w_alu_carry;
                r_zero   <= w_alu_zero;
                r_rsp_id <= r_id;
            end
            if (w_done && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_y      = r_y;
    assign rsp_carry  = r_carry;
    assign rsp_zero   = r_zero;
    assign done_cnt   = r_cnt;
endmodule
`default_nettype wire
